// File: rtl/apb_resp_mux.sv
// APB response multiplexer: routes the addressed slave's read data, ready and error
// back to the master, forcing an error completion on unmapped indices or wait-state timeouts.
module apb_resp_mux #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_SLAVES = 4,
   parameter int SEL_WIDTH  = 2,
   parameter int TIMEOUT    = 16
) (
   input  logic                             PCLK,
   input  logic                             PRESETn,
   input  logic                             PSEL,
   input  logic                             PENABLE,
   input  logic [SEL_WIDTH-1:0]             sel,
   input  logic [NUM_SLAVES*DATA_WIDTH-1:0] slv_prdata,
   input  logic [NUM_SLAVES-1:0]            slv_pready,
   input  logic [NUM_SLAVES-1:0]            slv_pslverr,
   input  logic                             err_clr,
   output logic [DATA_WIDTH-1:0]            PRDATA,
   output logic                             PREADY,
   output logic                             PSLVERR,
   output logic                             timeout,
   output logic [7:0]                       err_count
);

   typedef enum logic {IDLE, ACCESS} state_t;

   localparam logic [7:0] TIMEOUT_W = 8'(TIMEOUT);

   state_t                 state_q, state_d;
   logic [SEL_WIDTH-1:0]   idx_q, idx_d;
   logic [7:0]             wcnt_q, wcnt_d;
   logic [7:0]             err_count_q, err_count_d;

   logic                   sel_hit;
   logic                   sel_rdy;
   logic                   sel_err;
   logic [DATA_WIDTH-1:0]  sel_data;
   logic                   to_hit;
   logic                   err_inc;

   // Lane select from the latched index; sel_hit stays low for unmapped indices.
   always_comb begin
      sel_hit  = 1'b0;
      sel_rdy  = 1'b0;
      sel_err  = 1'b0;
      sel_data = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (idx_q == SEL_WIDTH'(i)) begin
            sel_hit  = 1'b1;
            sel_rdy  = slv_pready[i];
            sel_err  = slv_pslverr[i];
            sel_data = slv_prdata[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // A slave asserting ready in the limit cycle still wins over the timeout.
   assign to_hit = (TIMEOUT != 0) && sel_hit && (wcnt_q == TIMEOUT_W) && !sel_rdy;

   always_comb begin
      PRDATA  = '0;
      PREADY  = 1'b0;
      PSLVERR = 1'b0;
      timeout = 1'b0;
      if (state_q == ACCESS) begin
         if (!sel_hit) begin
            PREADY  = 1'b1;
            PSLVERR = 1'b1;
         end else if (to_hit) begin
            PREADY  = 1'b1;
            PSLVERR = 1'b1;
            timeout = 1'b1;
         end else begin
            PRDATA  = sel_data;
            PREADY  = sel_rdy;
            PSLVERR = sel_err & sel_rdy;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      wcnt_d  = wcnt_q;
      err_inc = 1'b0;
      case (state_q)
         IDLE: begin
            if (PSEL && !PENABLE) begin
               state_d = ACCESS;
               idx_d   = sel;
               wcnt_d  = '0;
            end
         end
         ACCESS: begin
            // A dropped PSEL is a master abort: leave quietly, nothing counted.
            if (!PSEL) begin
               state_d = IDLE;
            end else if (PREADY) begin
               state_d = IDLE;
               err_inc = !sel_hit || to_hit;
            end else if (wcnt_q != 8'hFF) begin
               wcnt_d = wcnt_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      err_count_d = err_count_q;
      if (err_clr) begin
         err_count_d = '0;
      end else if (err_inc && err_count_q != 8'hFF) begin
         err_count_d = err_count_q + 8'd1;
      end
   end

   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         wcnt_q      <= '0;
         err_count_q <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         wcnt_q      <= wcnt_d;
         err_count_q <= err_count_d;
      end
   end

   assign err_count = err_count_q;

endmodule

// File: tb/tb_apb_resp_mux.sv
// Directed bench for apb_resp_mux with three slaves (index 3 unmapped) and a 4-cycle timeout.
module tb_apb_resp_mux;

   localparam int DW = 8;
   localparam int NS = 3;
   localparam int SW = 2;
   localparam int TO = 4;

   logic            PCLK = 1'b0;
   logic            PRESETn;
   logic            PSEL;
   logic            PENABLE;
   logic [SW-1:0]   sel;
   logic [NS*DW-1:0] slv_prdata;
   logic [NS-1:0]   slv_pready;
   logic [NS-1:0]   slv_pslverr;
   logic            err_clr;
   logic [DW-1:0]   PRDATA;
   logic            PREADY;
   logic            PSLVERR;
   logic            timeout;
   logic [7:0]      err_count;

   int checks = 0;
   int errors = 0;

   apb_resp_mux #(.DATA_WIDTH(DW), .NUM_SLAVES(NS), .SEL_WIDTH(SW), .TIMEOUT(TO)) dut (
      .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .sel(sel),
      .slv_prdata(slv_prdata), .slv_pready(slv_pready), .slv_pslverr(slv_pslverr),
      .err_clr(err_clr), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
      .timeout(timeout), .err_count(err_count)
   );

   always #5 PCLK = ~PCLK;

   initial begin
      #400000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog");
   end

   task automatic set_lane(input int i, input logic [DW-1:0] v);
      slv_prdata[i*DW +: DW] = v;
   endtask

   task automatic setup(input logic [SW-1:0] s);
      @(posedge PCLK); #1;
      PSEL = 1'b1; PENABLE = 1'b0; sel = s;
   endtask

   task automatic enter_access();
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
   endtask

   task automatic advance();
      @(posedge PCLK); #1;
   endtask

   task automatic idle_bus();
      @(posedge PCLK); #1;
      PSEL = 1'b0; PENABLE = 1'b0;
   endtask

   task automatic test_reset();
      PRESETn = 1'b0; PSEL = 1'b1; PENABLE = 1'b0; sel = 2'd1; err_clr = 1'b0;
      slv_prdata = '1; slv_pready = '1; slv_pslverr = '1;
      repeat (3) @(posedge PCLK);
      #1; PSEL = 1'b0;
      @(negedge PCLK);
      checks++; if (PREADY !== 1'b0) begin errors++; $display("FAIL rst_pready got %0h exp 0", PREADY); end
      checks++; if (PSLVERR !== 1'b0) begin errors++; $display("FAIL rst_pslverr got %0h exp 0", PSLVERR); end
      checks++; if (PRDATA !== 8'h00) begin errors++; $display("FAIL rst_prdata got %0h exp 00", PRDATA); end
      checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL rst_timeout got %0h exp 0", timeout); end
      checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL rst_errcnt got %0d exp 0", err_count); end
      PRESETn = 1'b1;
      slv_prdata = '0; slv_pready = '0; slv_pslverr = '0;
   endtask

   task automatic test_mapped();
      set_lane(0, 8'h11); set_lane(1, 8'h22); set_lane(2, 8'hA5);
      slv_pready = 3'b111; slv_pslverr = 3'b011;
      setup(2'd2);
      enter_access();
      sel = 2'd0;
      @(negedge PCLK);
      checks++; if (PRDATA !== 8'hA5) begin errors++; $display("FAIL map_prdata got %0h exp a5", PRDATA); end
      checks++; if (PREADY !== 1'b1) begin errors++; $display("FAIL map_pready got %0h exp 1", PREADY); end
      checks++; if (PSLVERR !== 1'b0) begin errors++; $display("FAIL map_pslverr got %0h exp 0", PSLVERR); end
      idle_bus();
      @(negedge PCLK);
      checks++; if (PREADY !== 1'b0) begin errors++; $display("FAIL map_idle_pready got %0h exp 0", PREADY); end
      checks++; if (PRDATA !== 8'h00) begin errors++; $display("FAIL map_idle_prdata got %0h exp 00", PRDATA); end
   endtask

   task automatic test_wait();
      set_lane(1, 8'h3C); slv_pready = 3'b000; slv_pslverr = 3'b010;
      setup(2'd1);
      enter_access();
      for (int c = 1; c <= 3; c++) begin
         @(negedge PCLK);
         checks++; if (PREADY !== 1'b0) begin errors++; $display("FAIL wait_pready_c%0d got %0h exp 0", c, PREADY); end
         checks++; if (PSLVERR !== 1'b0) begin errors++; $display("FAIL wait_pslverr_c%0d got %0h exp 0", c, PSLVERR); end
         advance();
      end
      slv_pready = 3'b010;
      @(negedge PCLK);
      checks++; if (PREADY !== 1'b1) begin errors++; $display("FAIL wait_done_pready got %0h exp 1", PREADY); end
      checks++; if (PSLVERR !== 1'b1) begin errors++; $display("FAIL wait_done_pslverr got %0h exp 1", PSLVERR); end
      checks++; if (PRDATA !== 8'h3C) begin errors++; $display("FAIL wait_done_prdata got %0h exp 3c", PRDATA); end
      checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL wait_done_timeout got %0h exp 0", timeout); end
      idle_bus();
      @(negedge PCLK);
      checks++; if (PREADY !== 1'b0) begin errors++; $display("FAIL wait_idle_pready got %0h exp 0", PREADY); end
      checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL wait_errcnt got %0d exp 0", err_count); end
      slv_pready = '0; slv_pslverr = '0;
   endtask

   task automatic test_timeout();
      set_lane(0, 8'h77); slv_pready = 3'b000; slv_pslverr = 3'b001;
      setup(2'd0);
      enter_access();
      for (int c = 1; c <= 4; c++) begin
         @(negedge PCLK);
         checks++; if (PREADY !== 1'b0) begin errors++; $display("FAIL to_pready_c%0d got %0h exp 0", c, PREADY); end
         checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL to_timeout_c%0d got %0h exp 0", c, timeout); end
         advance();
      end
      @(negedge PCLK);
      checks++; if (PREADY !== 1'b1) begin errors++; $display("FAIL to_pready_c5 got %0h exp 1", PREADY); end
      checks++; if (PSLVERR !== 1'b1) begin errors++; $display("FAIL to_pslverr_c5 got %0h exp 1", PSLVERR); end
      checks++; if (PRDATA !== 8'h00) begin errors++; $display("FAIL to_prdata_c5 got %0h exp 00", PRDATA); end
      checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL to_timeout_c5 got %0h exp 1", timeout); end
      idle_bus();
      @(negedge PCLK);
      checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL to_errcnt got %0d exp 1", err_count); end
      checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL to_timeout_after got %0h exp 0", timeout); end
      slv_pslverr = '0;
   endtask

   task automatic test_ready_wins();
      set_lane(0, 8'h5E); slv_pready = 3'b000;
      setup(2'd0);
      enter_access();
      repeat (4) advance();
      slv_pready = 3'b001;
      @(negedge PCLK);
      checks++; if (PRDATA !== 8'h5E) begin errors++; $display("FAIL win_prdata got %0h exp 5e", PRDATA); end
      checks++; if (PSLVERR !== 1'b0) begin errors++; $display("FAIL win_pslverr got %0h exp 0", PSLVERR); end
      checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL win_timeout got %0h exp 0", timeout); end
      idle_bus();
      @(negedge PCLK);
      checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL win_errcnt got %0d exp 1", err_count); end
      slv_pready = '0;
   endtask

   task automatic test_unmapped();
      set_lane(0, 8'hF0); set_lane(1, 8'hF1); set_lane(2, 8'hF2);
      slv_pready = 3'b000; slv_pslverr = 3'b000;
      setup(2'd3);
      enter_access();
      @(negedge PCLK);
      checks++; if (PREADY !== 1'b1) begin errors++; $display("FAIL unm_pready got %0h exp 1", PREADY); end
      checks++; if (PSLVERR !== 1'b1) begin errors++; $display("FAIL unm_pslverr got %0h exp 1", PSLVERR); end
      checks++; if (PRDATA !== 8'h00) begin errors++; $display("FAIL unm_prdata got %0h exp 00", PRDATA); end
      checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL unm_timeout got %0h exp 0", timeout); end
      idle_bus();
      @(negedge PCLK);
      checks++; if (err_count !== 8'd2) begin errors++; $display("FAIL unm_errcnt got %0d exp 2", err_count); end
   endtask

   task automatic test_back_to_back();
      set_lane(0, 8'h00); set_lane(1, 8'h22); set_lane(2, 8'h11);
      slv_pready = 3'b110; slv_pslverr = 3'b000;
      setup(2'd2);
      enter_access();
      @(negedge PCLK);
      checks++; if (PRDATA !== 8'h11) begin errors++; $display("FAIL b2b_a_prdata got %0h exp 11", PRDATA); end
      checks++; if (PREADY !== 1'b1) begin errors++; $display("FAIL b2b_a_pready got %0h exp 1", PREADY); end
      advance();
      PENABLE = 1'b0; sel = 2'd1;
      @(negedge PCLK);
      checks++; if (PREADY !== 1'b0) begin errors++; $display("FAIL b2b_gap_pready got %0h exp 0", PREADY); end
      enter_access();
      @(negedge PCLK);
      checks++; if (PRDATA !== 8'h22) begin errors++; $display("FAIL b2b_b_prdata got %0h exp 22", PRDATA); end
      checks++; if (PREADY !== 1'b1) begin errors++; $display("FAIL b2b_b_pready got %0h exp 1", PREADY); end
      idle_bus();
      slv_pready = '0;
   endtask

   task automatic test_abort();
      set_lane(0, 8'h99); slv_pready = 3'b000;
      setup(2'd0);
      enter_access();
      advance();
      @(negedge PCLK);
      checks++; if (PREADY !== 1'b0) begin errors++; $display("FAIL abort_wait_pready got %0h exp 0", PREADY); end
      idle_bus();
      advance();
      slv_pready = 3'b001;
      @(negedge PCLK);
      checks++; if (PREADY !== 1'b0) begin errors++; $display("FAIL abort_idle_pready got %0h exp 0", PREADY); end
      checks++; if (err_count !== 8'd2) begin errors++; $display("FAIL abort_errcnt got %0d exp 2", err_count); end
      slv_pready = '0;
   endtask

   task automatic test_saturation();
      slv_pready = 3'b000;
      for (int n = 0; n < 256; n++) begin
         setup(2'd0);
         enter_access();
         repeat (4) advance();
         idle_bus();
         if (n == 251) begin
            @(negedge PCLK);
            checks++; if (err_count !== 8'd254) begin errors++; $display("FAIL sat_mid_errcnt got %0d exp 254", err_count); end
         end
      end
      @(negedge PCLK);
      checks++; if (err_count !== 8'd255) begin errors++; $display("FAIL sat_errcnt got %0d exp 255", err_count); end
   endtask

   task automatic test_clear();
      slv_pready = 3'b000;
      setup(2'd0);
      enter_access();
      repeat (4) advance();
      @(negedge PCLK);
      checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL clr_timeout got %0h exp 1", timeout); end
      err_clr = 1'b1;
      idle_bus();
      err_clr = 1'b0;
      @(negedge PCLK);
      checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL clr_errcnt got %0d exp 0", err_count); end
      setup(2'd3);
      enter_access();
      idle_bus();
      @(negedge PCLK);
      checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL clr_recount got %0d exp 1", err_count); end
   endtask

   task automatic test_reset_mid();
      set_lane(1, 8'hC3); slv_pready = 3'b000; slv_pslverr = 3'b010;
      setup(2'd1);
      enter_access();
      advance();
      PRESETn = 1'b0;
      slv_pready = 3'b010;
      advance();
      @(negedge PCLK);
      checks++; if (PREADY !== 1'b0) begin errors++; $display("FAIL rmid_pready got %0h exp 0", PREADY); end
      checks++; if (PSLVERR !== 1'b0) begin errors++; $display("FAIL rmid_pslverr got %0h exp 0", PSLVERR); end
      checks++; if (PRDATA !== 8'h00) begin errors++; $display("FAIL rmid_prdata got %0h exp 00", PRDATA); end
      checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL rmid_timeout got %0h exp 0", timeout); end
      checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL rmid_errcnt got %0d exp 0", err_count); end
      PRESETn = 1'b1;
      advance();
      @(negedge PCLK);
      checks++; if (PREADY !== 1'b0) begin errors++; $display("FAIL rmid_after_pready got %0h exp 0", PREADY); end
      idle_bus();
      slv_pready = '0; slv_pslverr = '0;
   endtask

   initial begin
      test_reset();
      test_mapped();
      test_wait();
      test_timeout();
      test_ready_wins();
      test_unmapped();
      test_back_to_back();
      test_abort();
      test_saturation();
      test_clear();
      test_reset_mid();
      repeat (2) @(posedge PCLK);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
